// File: rtl/core_pkg.sv
// Shared core definitions: PC-select encoding, sequencer states and reset/trap defaults.
package core_pkg;

    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;
    localparam logic [1:0] PCSEL_JALR   = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PENDING = 2'b10,
        ST_HALT    = 2'b11
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: branch > jump > jalr, jalr bit0 clear,
// misalignment detection and next-PC / mux-select generation.
module pc_redirect_arb
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC,
    parameter int              IALIGN   = 4
) (
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            jalr,
    input  logic [XLEN-1:0] jalr_target,
    output logic            redirect,
    output logic [1:0]      sel,
    output logic [XLEN-1:0] eff_target,
    output logic            misalign,
    output logic [XLEN-1:0] next_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    always_comb begin
        redirect   = branch | jump | jalr;
        sel        = PCSEL_SEQ;
        eff_target = '0;
        if (branch) begin
            sel        = PCSEL_BRANCH;
            eff_target = branch_target;
        end else if (jump) begin
            sel        = PCSEL_JUMP;
            eff_target = jump_target;
        end else if (jalr) begin
            sel        = PCSEL_JALR;
            eff_target = {jalr_target[XLEN-1:1], 1'b0};
        end
        misalign = redirect && ((eff_target & ALIGN_MASK) != '0);
        next_pc  = misalign ? TRAP_VEC : eff_target;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC unit: owns the fetch PC register, arbitrates EXE redirects, buffers a
// redirect that lands during a fetch stall, traps misaligned targets and supports halt.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC,
    parameter int              IALIGN   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            jalr,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [1:0]      pc_mux_select,
    output logic            flush,
    output logic            misalign_trap,
    output logic [XLEN-1:0] bad_addr
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] bad_q, bad_d;

    logic            redirect;
    logic [1:0]      sel;
    logic [XLEN-1:0] eff_target;
    logic            misalign;
    logic [XLEN-1:0] next_pc;

    pc_redirect_arb #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .IALIGN   (IALIGN)
    ) u_arb (
        .branch        (branch),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jalr          (jalr),
        .jalr_target   (jalr_target),
        .redirect      (redirect),
        .sel           (sel),
        .eff_target    (eff_target),
        .misalign      (misalign),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        trap_d        = 1'b0;
        bad_d         = bad_q;
        flush         = 1'b0;
        pc_mux_select = PCSEL_SEQ;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // Redirect still kills the IF instruction even when halt wins.
                flush         = redirect;
                pc_mux_select = sel;
                if (halt) begin
                    state_d = ST_HALT;
                    pend_d  = '0;
                end else if (redirect) begin
                    trap_d = misalign;
                    if (misalign) bad_d = eff_target;
                    if (stall) begin
                        pend_d  = next_pc;
                        state_d = ST_PENDING;
                    end else begin
                        pc_d = next_pc;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + XLEN'(IALIGN);
                end
            end
            ST_PENDING: begin
                if (halt) begin
                    state_d = ST_HALT;
                    pend_d  = '0;
                end else if (!stall) begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            trap_q  <= 1'b0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            trap_q  <= trap_d;
            bad_q   <= bad_d;
        end
    end

    assign pc            = pc_q;
    assign pc_valid      = (state_q == ST_RUN) || (state_q == ST_PENDING);
    assign misalign_trap = trap_q;
    assign bad_addr      = bad_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, halt, branch, jump, jalr;
    logic [31:0] branch_target, jump_target, jalr_target;

    logic [31:0] pc, bad_addr;
    logic        pc_valid, flush, misalign_trap;
    logic [1:0]  pc_mux_select;

    logic [31:0] pc2, bad_addr2;
    logic        pc_valid2, flush2, misalign_trap2;
    logic [1:0]  pc_mux_select2;

    always #5 clk = ~clk;

    pc_sequencer #(.IALIGN(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt),
        .branch(branch), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .jalr(jalr), .jalr_target(jalr_target),
        .pc(pc), .pc_valid(pc_valid), .pc_mux_select(pc_mux_select),
        .flush(flush), .misalign_trap(misalign_trap), .bad_addr(bad_addr)
    );

    pc_sequencer #(.IALIGN(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt),
        .branch(branch), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .jalr(jalr), .jalr_target(jalr_target),
        .pc(pc2), .pc_valid(pc_valid2), .pc_mux_select(pc_mux_select2),
        .flush(flush2), .misalign_trap(misalign_trap2), .bad_addr(bad_addr2)
    );

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic        vld;
        logic        flush;
        logic [1:0]  sel;
        logic        trap;
        logic [31:0] bad;
        logic        chk2;
        logic [31:0] pc2;
        logic        trap2;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        want2 = 1'b0;
    logic [31:0] want2_pc = '0;
    logic        want2_trap = 1'b0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "pc", pc, e.pc);
            chk(e.nm, "pc_valid", 32'(pc_valid), 32'(e.vld));
            chk(e.nm, "flush", 32'(flush), 32'(e.flush));
            chk(e.nm, "pc_mux_select", 32'(pc_mux_select), 32'(e.sel));
            chk(e.nm, "misalign_trap", 32'(misalign_trap), 32'(e.trap));
            chk(e.nm, "bad_addr", bad_addr, e.bad);
            if (e.chk2) begin
                chk(e.nm, "pc_ialign2", pc2, e.pc2);
                chk(e.nm, "trap_ialign2", 32'(misalign_trap2), 32'(e.trap2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0; halt = 1'b0;
        branch = 1'b0; jump = 1'b0; jalr = 1'b0;
        branch_target = '0; jump_target = '0; jalr_target = '0;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] p, input logic v, input logic f,
                              input logic [1:0] s, input logic t, input logic [31:0] b);
        exp_t e;
        e.nm = nm; e.pc = p; e.vld = v; e.flush = f; e.sel = s; e.trap = t; e.bad = b;
        e.chk2 = want2; e.pc2 = want2_pc; e.trap2 = want2_trap;
        want2 = 1'b0;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; halt = 1'b0;
        branch = 1'b0; jump = 1'b0; jalr = 1'b0;
        branch_target = '0; jump_target = '0; jalr_target = '0;
        repeat (2) @(posedge clk);

        tick(); reset = 1'b1; expect_out("rst_hold", 32'h0, 0, 0, 2'b00, 0, 32'h0);
        tick(); expect_out("boot", 32'h0, 0, 0, 2'b00, 0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(); expect_out("seq", 32'(i * 4), 1, 0, 2'b00, 0, 32'h0);
        end
        tick(); reset = 1'b1; expect_out("pre_rst", 32'h20, 1, 0, 2'b00, 0, 32'h0);
        tick(); expect_out("boot2", 32'h0, 0, 0, 2'b00, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out("seq2", 32'(i * 4), 1, 0, 2'b00, 0, 32'h0);
        end

        tick(); branch = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h80;
        expect_out("br_pri", 32'h10, 1, 1, 2'b01, 0, 32'h0);
        tick(); expect_out("br_tgt", 32'h40, 1, 0, 2'b00, 0, 32'h0);
        tick(); jump = 1'b1; jump_target = 32'h10;
        expect_out("jmp", 32'h44, 1, 1, 2'b10, 0, 32'h0);

        tick(); stall = 1'b1; jalr = 1'b1; jalr_target = 32'h61;
        expect_out("jalr_stall", 32'h10, 1, 1, 2'b11, 0, 32'h0);
        tick(); stall = 1'b1; branch = 1'b1; branch_target = 32'h200;
        expect_out("pend_ign", 32'h10, 1, 0, 2'b00, 0, 32'h0);
        tick(); stall = 1'b1; expect_out("pend_hold", 32'h10, 1, 0, 2'b00, 0, 32'h0);
        tick(); expect_out("pend_rel", 32'h10, 1, 0, 2'b00, 0, 32'h0);
        tick(); expect_out("jalr_tgt", 32'h60, 1, 0, 2'b00, 0, 32'h0);
        tick(); jump = 1'b1; jump_target = 32'h10;
        expect_out("jalr_seq", 32'h64, 1, 1, 2'b10, 0, 32'h0);

        tick(); jump = 1'b1; jump_target = 32'h42;
        expect_out("mis_jmp", 32'h10, 1, 1, 2'b10, 0, 32'h0);
        tick(); want2 = 1'b1; want2_pc = 32'h42; want2_trap = 1'b0;
        expect_out("trap", 32'h100, 1, 0, 2'b00, 1, 32'h42);
        tick(); jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        expect_out("post_trap", 32'h104, 1, 1, 2'b10, 0, 32'h42);
        tick(); expect_out("top", 32'hFFFF_FFFC, 1, 0, 2'b00, 0, 32'h42);
        tick(); jump = 1'b1; jump_target = 32'h20;
        expect_out("wrap", 32'h0, 1, 1, 2'b10, 0, 32'h42);

        tick(); halt = 1'b1; branch = 1'b1; branch_target = 32'h40;
        expect_out("halt_br", 32'h20, 1, 1, 2'b01, 0, 32'h42);
        tick(); branch = 1'b1; branch_target = 32'h40;
        expect_out("halt_ign", 32'h20, 0, 0, 2'b00, 0, 32'h42);
        tick(); jalr = 1'b1; jalr_target = 32'h80;
        expect_out("halt_ign2", 32'h20, 0, 0, 2'b00, 0, 32'h42);
        tick(); reset = 1'b1; expect_out("halt_rst", 32'h20, 0, 0, 2'b00, 0, 32'h42);
        tick(); expect_out("rst_boot", 32'h0, 0, 0, 2'b00, 0, 32'h0);
        tick(); expect_out("rst_run", 32'h0, 1, 0, 2'b00, 0, 32'h0);

        tick();
        tick();
        chk("drain", "queue_left", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-PC unit for the two-stage RISC-V core. It generalises the combinational PC-mux select logic into a block that owns the PC register. It arbitrates branch/jump/jalr redirects from EXE, and buffers a redirect that arrives while fetch is stalled. It also traps misaligned targets to a vector and supports halt. It sits between the EXE-stage control outputs and the IF-stage instruction memory address port.

Parameters:
XLEN, 32, PC / target width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on misaligned redirect target
IALIGN, 4, required target alignment in bytes (4, or 2 when compressed is enabled); also the sequential PC increment

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  IF cannot accept a new PC this cycle
halt  in  1  freeze fetch until reset
branch  in  1  taken conditional branch from EXE
branch_target  in  XLEN  branch target
jump  in  1  JAL from EXE
jump_target  in  XLEN  JAL target
jalr  in  1  JALR from EXE
jalr_target  in  XLEN  rs1+imm (bit0 cleared inside block)
pc  out  XLEN  current fetch address (registered)
pc_valid  out  1  pc is a valid fetch address
pc_mux_select  out  2  00 seq, 01 branch, 10 jump, 11 jalr; combinational, reflects the redirect chosen this cycle
flush  out  1  kill the instruction currently in IF; combinational, same cycle
misalign_trap  out  1  one-cycle registered pulse: a misaligned target was redirected to TRAP_VEC
bad_addr  out  XLEN  offending target, registered with misalign_trap, held until the next trap

Behaviour:
- Reset (synchronous, active-high, clk edge): pc=RESET_PC, state=BOOT, pc_valid=0, misalign_trap=0, bad_addr=0, pending cleared. Reset mid-operation discards any pending redirect.
- States: BOOT, RUN, PENDING, HALT.
- BOOT: pc_valid=0, flush=0, pc_mux_select=00. Moves to RUN on the next edge with pc unchanged, so the first valid fetch is RESET_PC.
- Redirect priority: branch > jump > jalr. pc_mux_select=01/10/11 accordingly, 00 if none.
- Effective target: the selected target; for jalr, bit0 is forced to 0.
- A target is misaligned if (target mod IALIGN) != 0. In that case next_pc=TRAP_VEC, misalign_trap pulses the cycle after, and bad_addr captures the effective target.
- Redirects are recognised only in RUN. They are ignored in BOOT, PENDING and HALT, because the upstream pipeline has already been flushed.
- RUN, no redirect, no stall: pc <= pc + IALIGN. Wraps modulo 2^XLEN.
- RUN, no redirect, stall: pc holds.
- RUN, redirect, no stall: pc <= next_pc, flush=1 this cycle. Latency is 1 clock from redirect to new pc.
- RUN, redirect, stall: flush=1 this cycle, next_pc is latched into the pending register, pc holds, state goes to PENDING. The misalign trap pulse and bad_addr update follow on the next edge as usual.
- PENDING: pc holds while stall=1. On the first cycle with stall=0, pc <= pending and state returns to RUN. flush=0 throughout PENDING.
- halt: highest priority in RUN or PENDING. The next edge enters HALT, pc holds, pc_valid=0, and any pending redirect is discarded. A redirect in the same cycle as halt is not taken, but flush still asserts. HALT exits only via reset.
- pc_valid=1 in RUN and PENDING.

Decomposition:
- Shared package core_pkg holds:
  - the PC-select encoding constants PCSEL_SEQ/BRANCH/JUMP/JALR (2'b00..2'b11), reused by the existing mux;
  - the state enum (BOOT/RUN/PENDING/HALT);
  - default RESET_PC and TRAP_VEC.
- One natural sub-module: pc_redirect_arb. It is combinational: priority select, jalr bit0 clear, misalign check, next_pc and pc_mux_select generation. The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset release, no stimulus -> cycle 1: pc=0x0, pc_valid=0. Then pc=0x0, 0x4, 0x8 with pc_valid=1. A second reset at pc=0x20 returns pc to 0x0 next edge.
- At pc=0x10, branch=1 with target 0x40 and jump=1 with target 0x80 in the same cycle -> flush=1, pc_mux_select=01 that cycle. Next: pc=0x40, then 0x44.
- At pc=0x10 with stall=1, jalr=1, jalr_target=0x61 -> flush=1, pc holds 0x10 for 3 stalled cycles. After stall drops: pc=0x60, then 0x64.
- At pc=0x10, jump_target=0x42 with IALIGN=4 -> pc=0x100 next edge, misalign_trap=1 for one cycle, bad_addr=0x42. Repeat with IALIGN=2 -> pc=0x42, no trap.
- pc=0xFFFF_FFFC, no redirect -> next pc=0x0000_0000.
- halt=1 with branch=1 at pc=0x20 -> flush=1, next pc stays 0x20, pc_valid=0. Later redirects are ignored until reset.
